// File: rtl/serial_rca_addsub.sv
// Digit-serial add/subtract: one DIGIT-bit ripple-carry slice is reused for
// WIDTH/DIGIT cycles, LSB digit first. Flags and sum are updated only on completion.
module serial_rca_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW    = DIGIT + 1;

  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("serial_rca_addsub: WIDTH must be a non-zero multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SW-1:0]      slice_c;
  logic [DIGIT-1:0]   s_dig_c;
  logic               c_next_c;
  logic [WIDTH-1:0]   res_c;
  logic               last_c;

  // Ripple slice on the low digit; its result is shifted into the top of the
  // A register, so after N cycles A holds the complete result.
  assign slice_c  = SW'(a_q[DIGIT-1:0]) + SW'(b_q[DIGIT-1:0]) + SW'(carry_q);
  assign s_dig_c  = slice_c[DIGIT-1:0];
  assign c_next_c = slice_c[DIGIT];
  assign res_c    = (WIDTH'(s_dig_c) << (WIDTH - DIGIT)) | (a_q >> DIGIT);
  assign last_c   = (cnt_q == CNT_W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          state_d = IDLE;
        end
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = res_c;
        b_d     = b_q >> DIGIT;
        carry_d = c_next_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_c) begin
          state_d = DONE;
          cnt_d   = '0;
          sum_d   = res_c;
          cout_d  = c_next_c;
          // carry into the MSB is a^b^s there; overflow is that XOR carry out
          ovf_d   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ s_dig_c[DIGIT-1] ^ c_next_c;
          zero_d  = (res_c == '0);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_rca_addsub.sv
// Directed bench for serial_rca_addsub: a 32/8 instance driven from a vector
// table plus hand sequences, and 8/1 and 8/8 instances for the digit extremes.
module tb_serial_rca_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start_v;
  logic        sub_i, cin_i;
  logic [31:0] a_i, b_i;
  logic [2:0]  busy_v, done_v, cout_v, ovf_v, zero_v;
  logic [31:0] sum0;
  logic [7:0]  sum1, sum2;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] last_sum [3];

  always #5 clk = ~clk;

  serial_rca_addsub #(.WIDTH(32), .DIGIT(8)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_i), .a(a_i), .b(b_i),
    .cin(cin_i), .busy(busy_v[0]), .done(done_v[0]), .sum(sum0),
    .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0]));

  serial_rca_addsub #(.WIDTH(8), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_i), .a(a_i[7:0]), .b(b_i[7:0]),
    .cin(cin_i), .busy(busy_v[1]), .done(done_v[1]), .sum(sum1),
    .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1]));

  serial_rca_addsub #(.WIDTH(8), .DIGIT(8)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_i), .a(a_i[7:0]), .b(b_i[7:0]),
    .cin(cin_i), .busy(busy_v[2]), .done(done_v[2]), .sum(sum2),
    .cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2]));

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [31:0] e_sum;
    logic        e_cout;
    logic        e_ovf;
    logic        e_zero;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [31:0] rd_sum(input int inst);
    case (inst)
      0:       return sum0;
      1:       return {24'h0, sum1};
      default: return {24'h0, sum2};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles after the start edge until done; also counts non-busy cycles
  task automatic wait_done(input int inst, output int cyc, output int gap);
    cyc = 0;
    gap = 0;
    while (!done_v[inst] && cyc < 40) begin
      if (!busy_v[inst]) gap++;
      step();
      cyc++;
    end
  endtask

  task automatic do_op(input int inst, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input int n, input logic [31:0] e_sum,
                       input logic e_cout, input logic e_ovf, input logic e_zero,
                       input string name);
    int cyc, gap;
    sub_i = s; a_i = a; b_i = b; cin_i = c;
    start_v[inst] = 1'b1;
    step();
    start_v[inst] = 1'b0;
    chk({name, " sum held in RUN"}, rd_sum(inst), last_sum[inst]);
    wait_done(inst, cyc, gap);
    chk({name, " latency"}, 32'(cyc), 32'(n));
    chk({name, " busy gaps"}, 32'(gap), 32'd0);
    chk({name, " sum"}, rd_sum(inst), e_sum);
    chk({name, " cout"}, 32'(cout_v[inst]), 32'(e_cout));
    chk({name, " ovf"}, 32'(ovf_v[inst]), 32'(e_ovf));
    chk({name, " zero"}, 32'(zero_v[inst]), 32'(e_zero));
    chk({name, " busy in DONE"}, 32'(busy_v[inst]), 32'd0);
    step();
    chk({name, " done one cycle"}, 32'(done_v[inst]), 32'd0);
    chk({name, " sum held in IDLE"}, rd_sum(inst), e_sum);
    last_sum[inst] = e_sum;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, gap, seen;
    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h00000007, 32'h00000005, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 32'h00000010, 32'h00000010, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; start_v = '0; sub_i = 1'b0; cin_i = 1'b0; a_i = '0; b_i = '0;
    last_sum[0] = '0; last_sum[1] = '0; last_sum[2] = '0;
    step();
    step();
    chk("reset busy", 32'(busy_v), 32'd0);
    chk("reset done", 32'(done_v), 32'd0);
    chk("reset sum0", sum0, 32'd0);
    chk("reset flags", {23'd0, cout_v, ovf_v, zero_v}, 32'd0);
    rst = 1'b0;
    step();

    foreach (vecs[i])
      do_op(0, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].c, 4, vecs[i].e_sum,
            vecs[i].e_cout, vecs[i].e_ovf, vecs[i].e_zero, $sformatf("vec%0d", i));

    // start during RUN is ignored
    sub_i = 1'b0; a_i = 32'd1; b_i = 32'd2; cin_i = 1'b0; start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    cyc = 0;
    step(); cyc++;
    sub_i = 1'b1; a_i = 32'd100; b_i = 32'd100; start_v[0] = 1'b1;
    step(); cyc++;
    start_v[0] = 1'b0;
    while (!done_v[0] && cyc < 40) begin step(); cyc++; end
    chk("ignore latency", 32'(cyc), 32'd4);
    chk("ignore sum", sum0, 32'd3);
    chk("ignore cout", 32'(cout_v[0]), 32'd0);
    step();
    chk("ignore no restart", 32'(busy_v[0]), 32'd0);

    // back-to-back: start held in DONE
    sub_i = 1'b0; a_i = 32'd10; b_i = 32'd20; cin_i = 1'b0; start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    wait_done(0, cyc, gap);
    chk("b2b first sum", sum0, 32'd30);
    sub_i = 1'b1; a_i = 32'd50; b_i = 32'd8; start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    chk("b2b busy after DONE", 32'(busy_v[0]), 32'd1);
    chk("b2b done dropped", 32'(done_v[0]), 32'd0);
    chk("b2b sum held", sum0, 32'd30);
    wait_done(0, cyc, gap);
    chk("b2b latency", 32'(cyc), 32'd4);
    chk("b2b busy gaps", 32'(gap), 32'd0);
    chk("b2b second sum", sum0, 32'd42);
    chk("b2b second cout", 32'(cout_v[0]), 32'd1);
    step();

    // async reset on the second RUN cycle
    sub_i = 1'b0; a_i = 32'd9; b_i = 32'd9; start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("rst busy", 32'(busy_v[0]), 32'd0);
    chk("rst done", 32'(done_v[0]), 32'd0);
    chk("rst sum", sum0, 32'd0);
    chk("rst flags", {29'd0, cout_v[0], ovf_v[0], zero_v[0]}, 32'd0);
    a_i = 32'd1; b_i = 32'd1; start_v[0] = 1'b1;
    step();
    chk("start ignored in rst", 32'(busy_v[0]), 32'd0);
    rst = 1'b0; start_v[0] = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done_v[0]) seen++;
    end
    chk("no done after abort", 32'(seen), 32'd0);
    last_sum[0] = '0;
    do_op(0, 1'b0, 32'd3, 32'd4, 1'b0, 4, 32'd7, 1'b0, 1'b0, 1'b0, "post-rst add");

    do_op(1, 1'b0, 32'h80, 32'h80, 1'b0, 8, 32'h00, 1'b1, 1'b1, 1'b1, "w8d1 add");
    do_op(1, 1'b1, 32'h03, 32'h05, 1'b0, 8, 32'hFE, 1'b0, 1'b0, 1'b0, "w8d1 sub");
    do_op(2, 1'b0, 32'h7F, 32'h01, 1'b0, 1, 32'h80, 1'b0, 1'b1, 1'b0, "w8d8 add");
    do_op(2, 1'b1, 32'h80, 32'h01, 1'b0, 1, 32'h7F, 1'b1, 1'b1, 1'b0, "w8d8 sub");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_rca_addsub.md
SERIAL_RCA_ADDSUB -- requirements
Module: serial_rca_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 8, bits processed per clock by one DIGIT-bit ripple-carry slice.
REQ-003 SHALL require WIDTH % DIGIT == 0 and DIGIT >= 1; N = WIDTH/DIGIT denotes digit count.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request to begin an operation; sampled on clk.
REQ-007 sub  input  1  0 = add, 1 = subtract; captured with start.
REQ-008 a  input  WIDTH  operand A; captured with start.
REQ-009 b  input  WIDTH  operand B; captured with start.
REQ-010 cin  input  1  carry-in for add; ignored when sub=1.
REQ-011 busy  output  1  high while operation in progress.
REQ-012 done  output  1  one-cycle pulse, result valid.
REQ-013 sum  output  WIDTH  registered result.
REQ-014 cout  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  high when sum == 0.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 In IDLE or DONE, start=1 SHALL capture a, (sub ? ~b : b), carry (sub ? 1 : cin), clear digit counter, enter RUN.
REQ-019 start while in RUN SHALL be ignored; captured operands unchanged.
REQ-020 Each RUN cycle SHALL add the lowest DIGIT bits of the captured operands plus the carry register, store the DIGIT-bit result, update carry, shift operands right by DIGIT.
REQ-021 Digits SHALL be processed LSB first; digit k result occupies bits [k*DIGIT+DIGIT-1 : k*DIGIT].
REQ-022 After digit N-1, FSM SHALL enter DONE and update sum, cout, ovf, zero in the same edge.
REQ-023 done SHALL be high exactly during DONE (one cycle), N cycles after the start-sampling edge; busy SHALL be high exactly during RUN.
REQ-024 DONE SHALL return to IDLE next edge unless start=1, then enter RUN (back-to-back, no dead cycle).
REQ-025 sum, cout, ovf, zero SHALL hold their previous values throughout RUN and IDLE until the next DONE.
REQ-026 Result: sum = (a + b + cin) mod 2^WIDTH for add; (a - b) mod 2^WIDTH for sub.
REQ-027 ovf SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-028 zero SHALL be computed from the final WIDTH-bit result.
REQ-029 DIGIT == WIDTH SHALL yield N=1: done one cycle after start.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, zero=0, carry and counter 0.
REQ-031 rst mid-RUN SHALL abort the operation; no done pulse for the aborted operation.
REQ-032 start SHALL be ignored while rst=1; first start after release SHALL be accepted normally.

Verification (WIDTH=32, DIGIT=8, N=4 unless noted)
REQ-033 add a=0xFFFFFFFF, b=0x00000001, cin=0 -> busy 4 cycles, done 4 cycles after start; sum=0x00000000, cout=1, ovf=0, zero=1.
REQ-034 add a=0x7FFFFFFF, b=0x00000000, cin=1 -> sum=0x80000000, cout=0, ovf=1, zero=0.
REQ-035 sub a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0, zero=0; sub a=7, b=5 -> sum=2, cout=1.
REQ-036 start re-asserted with new operands during RUN -> ignored, first result delivered; start held in DONE cycle -> second op accepted, second done exactly 4 cycles later, busy uninterrupted.
REQ-037 rst pulsed on 2nd RUN cycle -> all outputs 0 asynchronously, no done; next add a=3, b=4 -> sum=7 after 4 cycles.
REQ-038 WIDTH=8, DIGIT=1: add a=0x80, b=0x80, cin=0 -> done 8 cycles after start, sum=0x00, cout=1, ovf=1, zero=1.
